// File: rtl/sd_sector_responder.sv
// sd_sector_responder: moves one 256-word sector between a core buffer and word-addressed storage
//   clk_sys/reset_n : rising-edge clock, asynchronous active-low reset
//   sd_lba/sd_rd/sd_wr : sector request (read wins when both are high), sd_ack high during transfer
//   sd_buff_* : core buffer port (addr, write data + strobe, read data one cycle after addr)
//   st_* : storage port (addr {lba,idx}, rd/wr held until st_ready, wdata/rdata)
//   err : sticky flag for out-of-range sector or storage timeout, cleared on next accepted request
module sd_sector_responder #(
    parameter logic [31:0] MAX_LBA = 32'h0000_000F,
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [31:0] sd_lba,
    input  logic        sd_rd,
    input  logic        sd_wr,
    output logic        sd_ack,
    output logic [7:0]  sd_buff_addr,
    output logic [15:0] sd_buff_dout,
    output logic        sd_buff_wr,
    input  logic [15:0] sd_buff_din,
    output logic [39:0] st_addr,
    output logic        st_rd,
    output logic        st_wr,
    output logic [15:0] st_wdata,
    input  logic [15:0] st_rdata,
    input  logic        st_ready,
    output logic        err
);
    typedef enum logic [2:0] {IDLE, START, RD_REQ, RD_PUT, WR_ADDR, WR_LAT, WR_REQ, DONE} state_t;
    state_t      state_q;
    logic [31:0] lba_q;
    logic [7:0]  idx_q;
    logic [7:0]  idx_d;
    logic [15:0] cnt_q;
    logic [15:0] dout_q;
    logic [15:0] wdata_q;
    logic        rd_q;
    logic        ack_q;
    logic        buff_wr_q;
    logic        st_rd_q;
    logic        st_wr_q;
    logic        err_q;
    logic        oor;
    logic        timed_out;
    logic        word_done;
    always_comb begin
        oor       = lba_q > MAX_LBA;
        timed_out = cnt_q == TIMEOUT - 16'd1;
        // an out-of-range sector never talks to storage, so its words finish at once
        word_done = oor || st_ready || timed_out;
        idx_d     = idx_q + 8'd1;
    end
    assign sd_ack       = ack_q;
    assign sd_buff_addr = idx_q;
    assign sd_buff_dout = dout_q;
    assign sd_buff_wr   = buff_wr_q;
    assign st_addr      = {lba_q, idx_q};
    assign st_rd        = st_rd_q;
    assign st_wr        = st_wr_q;
    assign st_wdata     = wdata_q;
    assign err          = err_q;
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            lba_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            wdata_q   <= '0;
            rd_q      <= 1'b0;
            ack_q     <= 1'b0;
            buff_wr_q <= 1'b0;
            st_rd_q   <= 1'b0;
            st_wr_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            buff_wr_q <= 1'b0;
            case (state_q)
                IDLE: if ((sd_rd || sd_wr) && !ack_q) begin
                    lba_q   <= sd_lba;
                    rd_q    <= sd_rd;
                    err_q   <= 1'b0;
                    idx_q   <= '0;
                    ack_q   <= 1'b1;
                    state_q <= START;
                end
                START: begin
                    if (oor) err_q <= 1'b1;
                    cnt_q   <= '0;
                    st_rd_q <= rd_q && !oor;
                    state_q <= rd_q ? RD_REQ : WR_ADDR;
                end
                RD_REQ: if (word_done) begin
                    st_rd_q   <= 1'b0;
                    buff_wr_q <= 1'b1;
                    // a timed-out or out-of-range word is delivered as zero
                    dout_q    <= (!oor && st_ready) ? st_rdata : 16'h0000;
                    if (!oor && !st_ready) err_q <= 1'b1;
                    state_q   <= RD_PUT;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                RD_PUT: begin
                    idx_q <= idx_d;
                    cnt_q <= '0;
                    if (idx_q == 8'hFF) begin
                        ack_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        st_rd_q <= !oor;
                        state_q <= RD_REQ;
                    end
                end
                WR_ADDR: state_q <= WR_LAT;
                WR_LAT: begin
                    wdata_q <= sd_buff_din;
                    st_wr_q <= !oor;
                    cnt_q   <= '0;
                    state_q <= WR_REQ;
                end
                WR_REQ: if (word_done) begin
                    st_wr_q <= 1'b0;
                    if (!oor && !st_ready) err_q <= 1'b1;
                    idx_q   <= idx_d;
                    if (idx_q == 8'hFF) begin
                        ack_q   <= 1'b0;
                        state_q <= DONE;
                    end else begin
                        state_q <= WR_ADDR;
                    end
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                end
                DONE: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_sector_responder.sv
// tb_sd_sector_responder: scoreboard bench for sd_sector_responder with storage and buffer models
module tb_sd_sector_responder;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] sd_lba = '0;
    logic        sd_rd = 1'b0;
    logic        sd_wr = 1'b0;
    logic        sd_ack;
    logic [7:0]  sd_buff_addr;
    logic [15:0] sd_buff_dout;
    logic        sd_buff_wr;
    logic [15:0] sd_buff_din = '0;
    logic [39:0] st_addr;
    logic        st_rd;
    logic        st_wr;
    logic [15:0] st_wdata;
    logic [15:0] st_rdata = '0;
    logic        st_ready = 1'b0;
    logic        err;

    sd_sector_responder dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .st_addr(st_addr), .st_rd(st_rd),
        .st_wr(st_wr), .st_wdata(st_wdata), .st_rdata(st_rdata), .st_ready(st_ready), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          kind;
        logic [39:0] addr;
        logic [15:0] data;
    } exp_t;
    exp_t q[$];

    int total = 0;
    int bad = 0;
    int ack_cycles = 0;
    int rd_cycles = 0;
    int hold_idx = -1;
    int wcnt = 0;
    logic [15:0] buf_mem [256];

    // storage: ready two cycles after a request, read data = low 16 bits of the address
    always @(posedge clk_sys) begin
        if ((st_rd || st_wr) && !st_ready) begin
            if (wcnt == 1 && !(st_rd && int'(st_addr[7:0]) == hold_idx)) begin
                st_ready <= 1'b1;
                st_rdata <= st_addr[15:0];
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            st_ready <= 1'b0;
            st_rdata <= 16'hBEEF;
            wcnt     <= 0;
        end
    end

    always @(posedge clk_sys) sd_buff_din <= buf_mem[sd_buff_addr];

    task automatic check_evt(input bit kind, input logic [39:0] addr, input logic [15:0] data);
        exp_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_evt: kind=%0d addr=%h data=%h, none expected", kind, addr, data);
        end else begin
            e = q.pop_front();
            if (e.kind !== kind || e.addr !== addr || e.data !== data) begin
                bad++;
                $display("FAIL evt: got kind=%0d addr=%h data=%h, want kind=%0d addr=%h data=%h",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
        total++;
        if (sd_ack !== 1'b1) begin
            bad++;
            $display("FAIL ack_during_word: got %b want 1", sd_ack);
        end
    endtask

    always @(negedge clk_sys) if (reset_n) begin
        if (sd_ack) ack_cycles++;
        if (st_rd) rd_cycles++;
        if (st_rd && st_wr) begin
            total++;
            bad++;
            $display("FAIL st_exclusive: st_rd=%b st_wr=%b want not both", st_rd, st_wr);
        end
        if (sd_buff_wr) check_evt(1'b0, {32'h0, sd_buff_addr}, sd_buff_dout);
        if (st_wr && st_ready) check_evt(1'b1, st_addr, st_wdata);
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [31:0] lba);
        @(negedge clk_sys);
        sd_lba = lba;
        sd_rd = rd;
        sd_wr = wr;
        @(negedge clk_sys);
        sd_rd = 1'b0;
        sd_wr = 1'b0;
        chk("ack_rise", {63'h0, sd_ack}, 64'h1);
    endtask

    task automatic push_rd(input logic [7:0] l, input int zero_idx, input bit all_zero);
        for (int i = 0; i < 256; i++)
            q.push_back('{1'b0, 40'(i), (all_zero || i == zero_idx) ? 16'h0000 : {l, 8'(i)}});
    endtask

    task automatic wait_done(input int budget, input string nm);
        int n = 0;
        bit seen = 0;
        while (n < budget && !(seen && !sd_ack)) begin
            @(negedge clk_sys);
            if (sd_ack) seen = 1;
            n++;
        end
        total++;
        if (!(seen && !sd_ack)) begin
            bad++;
            $display("FAIL %s_done: not finished within %0d cycles", nm, budget);
        end
        chk({nm, "_queue_left"}, 64'(q.size()), 64'h0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) buf_mem[i] = ~16'(i);
        repeat (3) @(negedge clk_sys);
        chk("reset_ctrl", {59'h0, sd_ack, sd_buff_wr, st_rd, st_wr, err}, 64'h0);
        chk("reset_addr", {16'h0, st_addr, sd_buff_addr}, 64'h0);
        reset_n = 1'b1;

        // read lba 3
        ack_cycles = 0;
        push_rd(8'h03, -1, 1'b0);
        issue(1'b1, 1'b0, 32'd3);
        wait_done(3000, "rd3");
        chk("rd3_ack_cycles", 64'(ack_cycles), 64'd1025);
        chk("rd3_err", {63'h0, err}, 64'h0);

        // write lba 5, buffer word i = ~i
        ack_cycles = 0;
        for (int i = 0; i < 256; i++) q.push_back('{1'b1, {32'd5, 8'(i)}, ~16'(i)});
        issue(1'b0, 1'b1, 32'd5);
        wait_done(3000, "wr5");
        chk("wr5_ack_cycles", 64'(ack_cycles), 64'd1281);
        chk("wr5_err", {63'h0, err}, 64'h0);

        // out-of-range read
        ack_cycles = 0;
        rd_cycles = 0;
        push_rd(8'h10, -1, 1'b1);
        issue(1'b1, 1'b0, 32'd16);
        wait_done(2000, "oor");
        chk("oor_err", {63'h0, err}, 64'h1);
        chk("oor_st_rd", 64'(rd_cycles), 64'h0);
        chk("oor_ack_cycles", 64'(ack_cycles), 64'd513);

        // read and write together: read wins, err cleared, mid-transfer write ignored
        push_rd(8'h02, -1, 1'b0);
        issue(1'b1, 1'b1, 32'd2);
        chk("both_err_cleared", {63'h0, err}, 64'h0);
        repeat (300) @(negedge clk_sys);
        sd_wr = 1'b1;
        sd_lba = 32'd9;
        repeat (3) @(negedge clk_sys);
        sd_wr = 1'b0;
        wait_done(3000, "both");
        repeat (10) @(negedge clk_sys);
        chk("both_no_restart", {63'h0, sd_ack}, 64'h0);

        // storage timeout on word 7
        hold_idx = 7;
        push_rd(8'h01, 7, 1'b0);
        issue(1'b1, 1'b0, 32'd1);
        wait_done(4000, "tmo");
        chk("tmo_err", {63'h0, err}, 64'h1);
        hold_idx = -1;

        // reset during word 100, then a fresh read restarts at index 0
        push_rd(8'h04, -1, 1'b0);
        issue(1'b1, 1'b0, 32'd4);
        for (int n = 0; n < 2000 && q.size() > 156; n++) @(negedge clk_sys);
        chk("mid_reached", 64'(q.size() <= 156), 64'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_ctrl", {59'h0, sd_ack, sd_buff_wr, st_rd, st_wr, err}, 64'h0);
        chk("async_addr", {16'h0, st_addr, sd_buff_addr}, 64'h0);
        chk("async_data", {32'h0, sd_buff_dout, st_wdata}, 64'h0);
        q.delete();
        repeat (2) @(negedge clk_sys);
        reset_n = 1'b1;
        push_rd(8'h06, -1, 1'b0);
        issue(1'b1, 1'b0, 32'd6);
        wait_done(3000, "after_rst");
        chk("after_rst_err", {63'h0, err}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
